// File: rtl/hpim2axi4l_adp.sv
// hpim2axi4l_adp: local CPU strobe interface to AXI4-Lite master bridge.
// Accepts single-cycle cpu_wr / cpu_rd requests and runs one AXI4-Lite
// transaction at a time. A read that arrives together with a write is
// parked in a one-deep pending slot and issued after the write completes.
// Each transaction is guarded by a timeout counter for bus-hang recovery.
// Ports:
//   aclk, areset               clock, asynchronous active-high reset
//   cpu_wr/_addr/_strb/_data   write request from the local controller
//   cpu_rd/_addr               read request from the local controller
//   cpu_busy                   transaction in flight or read pending
//   cpu_wr_done, cpu_rd_vld    one-cycle completion strobes
//   cpu_rd_data, cpu_err       read data (held) and completion status
//   aw*/w*/b*/ar*/r*           AXI4-Lite master channels
module hpim2axi4l_adp #(
  parameter int ADDR_WIDTH    = 21,
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_BYTE_NUM = DATA_WIDTH/8,
  parameter int TO_WIDTH      = 8,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cpu_wr,
  input  logic [ADDR_WIDTH-1:0]    cpu_wr_addr,
  input  logic [DATA_BYTE_NUM-1:0] cpu_wr_strb,
  input  logic [DATA_WIDTH-1:0]    cpu_wr_data,
  input  logic                     cpu_rd,
  input  logic [ADDR_WIDTH-1:0]    cpu_rd_addr,
  output logic                     cpu_busy,
  output logic                     cpu_wr_done,
  output logic                     cpu_rd_vld,
  output logic [DATA_WIDTH-1:0]    cpu_rd_data,
  output logic                     cpu_err,
  output logic                     awvalid,
  output logic [ADDR_WIDTH-1:0]    awaddr,
  input  logic                     awready,
  output logic                     wvalid,
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_BYTE_NUM-1:0] wstrb,
  input  logic                     wready,
  input  logic                     bvalid,
  input  logic [1:0]               bresp,
  output logic                     bready,
  output logic                     arvalid,
  output logic [ADDR_WIDTH-1:0]    araddr,
  input  logic                     arready,
  input  logic                     rvalid,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  output logic                     rready
);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_WR_AD   = 5'b00010,
    S_WR_RESP = 5'b00100,
    S_RD_ADDR = 5'b01000,
    S_RD_DATA = 5'b10000
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_MAX = {TO_WIDTH{1'b1}};
  localparam logic [TO_WIDTH-1:0] TO_ONE = {{(TO_WIDTH-1){1'b0}}, 1'b1};

  state_t                   r_state, w_state_nxt;
  logic                     r_awvalid, w_awvalid_nxt, r_wvalid, w_wvalid_nxt;
  logic                     r_bready, w_bready_nxt, r_arvalid, w_arvalid_nxt;
  logic                     r_rready, w_rready_nxt;
  logic [ADDR_WIDTH-1:0]    r_awaddr, w_awaddr_nxt, r_araddr, w_araddr_nxt;
  logic [DATA_WIDTH-1:0]    r_wdata, w_wdata_nxt, r_rd_data, w_rd_data_nxt;
  logic [DATA_BYTE_NUM-1:0] r_wstrb, w_wstrb_nxt;
  logic                     r_pend, w_pend_nxt;
  logic [ADDR_WIDTH-1:0]    r_pend_addr, w_pend_addr_nxt;
  logic [TO_WIDTH-1:0]      r_to_cnt, w_to_cnt_nxt;
  logic                     r_wr_done, w_wr_done_nxt, r_rd_vld, w_rd_vld_nxt;
  logic                     r_err, w_err_nxt;
  logic                     w_aw_done, w_w_done, w_timeout;

  // A channel counts as done if its handshake already happened (valid dropped)
  // or is happening this cycle.
  assign w_aw_done = !r_awvalid || awready;
  assign w_w_done  = !r_wvalid  || wready;
  assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == TO_MAX);

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_awaddr_nxt    = r_awaddr;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_araddr_nxt    = r_araddr;
    w_rd_data_nxt   = r_rd_data;
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    w_wr_done_nxt   = 1'b0;
    w_rd_vld_nxt    = 1'b0;
    w_err_nxt       = 1'b0;
    if (r_state == S_IDLE) begin
      w_to_cnt_nxt = {TO_WIDTH{1'b0}};
    end else begin
      w_to_cnt_nxt = r_to_cnt + TO_ONE;
    end

    case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          // Parked read has priority; cpu_wr/cpu_rd are ignored while busy.
          w_araddr_nxt  = r_pend_addr;
          w_arvalid_nxt = 1'b1;
          w_pend_nxt    = 1'b0;
          w_state_nxt   = S_RD_ADDR;
        end else if (cpu_wr) begin
          w_awaddr_nxt  = cpu_wr_addr;
          w_wdata_nxt   = cpu_wr_data;
          w_wstrb_nxt   = cpu_wr_strb;
          w_awvalid_nxt = 1'b1;
          w_wvalid_nxt  = 1'b1;
          w_state_nxt   = S_WR_AD;
          if (cpu_rd) begin
            w_pend_nxt      = 1'b1;
            w_pend_addr_nxt = cpu_rd_addr;
          end else begin
            w_pend_nxt      = 1'b0;
          end
        end else if (cpu_rd) begin
          w_araddr_nxt  = cpu_rd_addr;
          w_arvalid_nxt = 1'b1;
          w_state_nxt   = S_RD_ADDR;
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_WR_AD: begin
        if (w_aw_done && w_w_done) begin
          w_awvalid_nxt = 1'b0;
          w_wvalid_nxt  = 1'b0;
          w_bready_nxt  = 1'b1;
          w_state_nxt   = S_WR_RESP;
        end else begin
          w_awvalid_nxt = r_awvalid && !awready;
          w_wvalid_nxt  = r_wvalid && !wready;
        end
      end
      S_WR_RESP: begin
        if (bvalid) begin
          w_bready_nxt  = 1'b0;
          w_wr_done_nxt = 1'b1;
          w_err_nxt     = (bresp != 2'b00);
          w_state_nxt   = S_IDLE;
        end else begin
          w_state_nxt   = S_WR_RESP;
        end
      end
      S_RD_ADDR: begin
        if (arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RD_DATA;
        end else begin
          w_state_nxt   = S_RD_ADDR;
        end
      end
      S_RD_DATA: begin
        if (rvalid) begin
          w_rready_nxt  = 1'b0;
          w_rd_data_nxt = (rresp == 2'b00) ? rdata : ERR_DATA;
          w_rd_vld_nxt  = 1'b1;
          w_err_nxt     = (rresp != 2'b00);
          w_state_nxt   = S_IDLE;
        end else begin
          w_state_nxt   = S_RD_DATA;
        end
      end
      default: begin
        w_awvalid_nxt = 1'b0;
        w_wvalid_nxt  = 1'b0;
        w_bready_nxt  = 1'b0;
        w_arvalid_nxt = 1'b0;
        w_rready_nxt  = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase

    // Hang recovery: drop every valid/ready regardless of AXI hold rules and
    // report the stuck transaction as failed. The pending read survives.
    if (w_timeout) begin
      w_awvalid_nxt = 1'b0;
      w_wvalid_nxt  = 1'b0;
      w_bready_nxt  = 1'b0;
      w_arvalid_nxt = 1'b0;
      w_rready_nxt  = 1'b0;
      w_state_nxt   = S_IDLE;
      w_err_nxt     = 1'b1;
      if ((r_state == S_WR_AD) || (r_state == S_WR_RESP)) begin
        w_wr_done_nxt = 1'b1;
        w_rd_vld_nxt  = 1'b0;
      end else begin
        w_wr_done_nxt = 1'b0;
        w_rd_vld_nxt  = 1'b1;
        w_rd_data_nxt = ERR_DATA;
      end
    end else begin
      w_err_nxt = w_err_nxt;
    end
  end

  // State and output registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state     <= S_IDLE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= {ADDR_WIDTH{1'b0}};
      r_wdata     <= {DATA_WIDTH{1'b0}};
      r_wstrb     <= {DATA_BYTE_NUM{1'b0}};
      r_araddr    <= {ADDR_WIDTH{1'b0}};
      r_rd_data   <= {DATA_WIDTH{1'b0}};
      r_pend      <= 1'b0;
      r_pend_addr <= {ADDR_WIDTH{1'b0}};
      r_to_cnt    <= {TO_WIDTH{1'b0}};
      r_wr_done   <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_araddr    <= w_araddr_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_wr_done   <= w_wr_done_nxt;
      r_rd_vld    <= w_rd_vld_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign cpu_busy    = (r_state != S_IDLE) || r_pend;
  assign cpu_wr_done = r_wr_done;
  assign cpu_rd_vld  = r_rd_vld;
  assign cpu_rd_data = r_rd_data;
  assign cpu_err     = r_err;
  assign awvalid     = r_awvalid;
  assign awaddr      = r_awaddr;
  assign wvalid      = r_wvalid;
  assign wdata       = r_wdata;
  assign wstrb       = r_wstrb;
  assign bready      = r_bready;
  assign arvalid     = r_arvalid;
  assign araddr      = r_araddr;
  assign rready      = r_rready;

endmodule

// File: tb/tb_hpim2axi4l_adp.sv
// Bench for hpim2axi4l_adp: directed CPU requests against a configurable
// AXI4-Lite slave. A transaction-level model (expected AXI transfers and
// expected CPU completions, plus an outstanding-request count for busy)
// is checked every cycle by one compare process.
module tb_hpim2axi4l_adp;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cpu_wr, cpu_rd;
  logic [20:0] cpu_wr_addr, cpu_rd_addr;
  logic [3:0]  cpu_wr_strb;
  logic [31:0] cpu_wr_data;
  logic        cpu_busy, cpu_wr_done, cpu_rd_vld, cpu_err;
  logic [31:0] cpu_rd_data;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [20:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  hpim2axi4l_adp dut (
    .aclk(aclk), .areset(areset),
    .cpu_wr(cpu_wr), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_strb(cpu_wr_strb),
    .cpu_wr_data(cpu_wr_data), .cpu_rd(cpu_rd), .cpu_rd_addr(cpu_rd_addr),
    .cpu_busy(cpu_busy), .cpu_wr_done(cpu_wr_done), .cpu_rd_vld(cpu_rd_vld),
    .cpu_rd_data(cpu_rd_data), .cpu_err(cpu_err),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed { logic wr; logic [20:0] addr; logic [31:0] data; logic [3:0] strb; } axi_t;
  typedef struct packed { logic wr; logic err; logic [31:0] data; } cpl_t;

  axi_t exp_axi[$];
  axi_t obs_axi[$];
  cpl_t exp_cpl[$];
  int   outstanding = 0;
  int   total = 0;
  int   bad = 0;

  // slave configuration
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic        b_en = 1'b1, r_en = 1'b1;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;
  logic        slv_clr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [1:0] resp, input logic [31:0] d);
    return (resp == 2'b00) ? d : 32'hDEAD_BEEF;
  endfunction

  // Issue a CPU request; the model expectations are pushed from the slave config.
  task automatic issue(input logic wr, input logic rd, input logic [20:0] wa,
                       input logic [31:0] wd, input logic [3:0] ws, input logic [20:0] ra);
    axi_t a;
    cpl_t c;
    if (wr) begin
      a = '{wr: 1'b1, addr: wa, data: wd, strb: ws};
      exp_axi.push_back(a);
      c = '{wr: 1'b1, err: b_en ? (b_resp_cfg != 2'b00) : 1'b1, data: 32'h0};
      exp_cpl.push_back(c);
    end
    if (rd) begin
      a = '{wr: 1'b0, addr: ra, data: 32'h0, strb: 4'h0};
      exp_axi.push_back(a);
      c = '{wr: 1'b0, err: r_en ? (r_resp_cfg != 2'b00) : 1'b1,
            data: r_en ? rd_model(r_resp_cfg, r_data_cfg) : 32'hDEAD_BEEF};
      exp_cpl.push_back(c);
    end
    @(posedge aclk); #2;
    cpu_wr = wr; cpu_wr_addr = wa; cpu_wr_data = wd; cpu_wr_strb = ws;
    cpu_rd = rd; cpu_rd_addr = ra;
    @(posedge aclk); #1;
    outstanding = outstanding + int'(wr) + int'(rd);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  // Wait for one completion strobe; n = negedges counted until it shows.
  task automatic wait_cpl(input int budget, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge aclk);
      n++;
      if (cpu_wr_done || cpu_rd_vld) seen = 1'b1;
    end
    chk("cpl_wait", seen, 1'b1);
  endtask

  // AXI4-Lite slave: programmable ready delays, responses, hang options.
  initial begin
    int aw_w, w_w, ar_w;
    logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
    logic [20:0] p_awaddr, p_araddr, aw_a;
    logic [31:0] p_wdata, w_d;
    logic [3:0]  p_wstrb, w_s;
    logic aw_seen, w_seen, bpend, rpend;
    axi_t o;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_w = 0; w_w = 0; ar_w = 0; aw_seen = 0; w_seen = 0; bpend = 0; rpend = 0;
    {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
    p_awaddr = 0; p_araddr = 0; p_wdata = 0; p_wstrb = 0; aw_a = 0; w_d = 0; w_s = 0;
    forever begin
      @(posedge aclk); #1;
      if (areset) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = 0;
        aw_w = 0; w_w = 0; ar_w = 0; aw_seen = 0; w_seen = 0; bpend = 0; rpend = 0;
        {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
      end else begin
        if (slv_clr) begin aw_seen = 0; w_seen = 0; bpend = 0; slv_clr = 1'b0; end
        if (p_awv && p_awr) begin aw_seen = 1; aw_a = p_awaddr; end
        if (p_wv && p_wr) begin w_seen = 1; w_d = p_wdata; w_s = p_wstrb; end
        if (aw_seen && w_seen && !bpend) begin
          o = '{wr: 1'b1, addr: aw_a, data: w_d, strb: w_s};
          obs_axi.push_back(o);
          bpend = 1;
        end
        if (p_bv && p_br) begin bpend = 0; aw_seen = 0; w_seen = 0; end
        if (p_arv && p_arr) begin
          o = '{wr: 1'b0, addr: p_araddr, data: 32'h0, strb: 4'h0};
          obs_axi.push_back(o);
          rpend = 1;
        end
        if (p_rv && p_rr) rpend = 0;
        bvalid = bpend && b_en; bresp = b_resp_cfg;
        rvalid = rpend && r_en; rresp = r_resp_cfg; rdata = rvalid ? r_data_cfg : 32'h0;
        awready = awvalid && (aw_w >= aw_dly); aw_w = awvalid ? aw_w + 1 : 0;
        wready  = wvalid  && (w_w  >= w_dly);  w_w  = wvalid  ? w_w + 1  : 0;
        arready = arvalid && (ar_w >= ar_dly); ar_w = arvalid ? ar_w + 1 : 0;
        p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
        p_bv = bvalid; p_br = bready; p_arv = arvalid; p_arr = arready;
        p_rv = rvalid; p_rr = rready;
        p_awaddr = awaddr; p_araddr = araddr; p_wdata = wdata; p_wstrb = wstrb;
      end
    end
  end

  // Compare process: DUT against the transaction model every cycle.
  initial begin
    logic pv_awv, pv_awr, pv_wv, pv_wr, pv_arv, pv_arr, to_now;
    logic [20:0] pv_awaddr, pv_araddr;
    logic [31:0] pv_wdata;
    logic [3:0]  pv_wstrb;
    axi_t o, e;
    cpl_t c;
    {pv_awv, pv_awr, pv_wv, pv_wr, pv_arv, pv_arr} = '0;
    pv_awaddr = 0; pv_araddr = 0; pv_wdata = 0; pv_wstrb = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        chk("rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, cpu_busy, cpu_wr_done, cpu_rd_vld, cpu_err}, 64'h0);
        chk("rst_addr", {awaddr, araddr}, 64'h0);
        chk("rst_data", {wdata, cpu_rd_data}, 64'h0);
        chk("rst_strb", wstrb, 64'h0);
        {pv_awv, pv_awr, pv_wv, pv_wr, pv_arv, pv_arr} = '0;
      end else begin
        while (obs_axi.size() > 0) begin
          o = obs_axi.pop_front();
          chk("axi_expected", exp_axi.size() != 0, 1'b1);
          if (exp_axi.size() != 0) begin
            e = exp_axi.pop_front();
            chk("axi_kind", o.wr, e.wr);
            chk("axi_addr", o.addr, e.addr);
            if (e.wr) begin
              chk("axi_wdata", o.data, e.data);
              chk("axi_wstrb", o.strb, e.strb);
            end
          end
        end
        to_now = 1'b0;
        if (cpu_wr_done || cpu_rd_vld) begin
          to_now = cpu_err;
          chk("cpl_expected", exp_cpl.size() != 0, 1'b1);
          if (exp_cpl.size() != 0) begin
            c = exp_cpl.pop_front();
            chk("cpl_kind", {cpu_wr_done, cpu_rd_vld}, {c.wr, !c.wr});
            chk("cpl_err", cpu_err, c.err);
            if (!c.wr) chk("cpl_rdata", cpu_rd_data, c.data);
          end
          outstanding--;
        end
        chk("busy", cpu_busy, outstanding != 0);
        if (pv_awv && !pv_awr && !to_now) chk("aw_hold", {awvalid, awaddr}, {1'b1, pv_awaddr});
        if (pv_wv && !pv_wr && !to_now)   chk("w_hold", {wvalid, wstrb, wdata}, {1'b1, pv_wstrb, pv_wdata});
        if (pv_arv && !pv_arr && !to_now) chk("ar_hold", {arvalid, araddr}, {1'b1, pv_araddr});
        pv_awv = awvalid; pv_awr = awready; pv_wv = wvalid; pv_wr = wready;
        pv_arv = arvalid; pv_arr = arready;
        pv_awaddr = awaddr; pv_araddr = araddr; pv_wdata = wdata; pv_wstrb = wstrb;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed test sequence.
  initial begin
    int n;
    areset = 1'b1;
    cpu_wr = 0; cpu_rd = 0; cpu_wr_addr = 0; cpu_rd_addr = 0; cpu_wr_strb = 0; cpu_wr_data = 0;
    repeat (3) @(posedge aclk);
    #2 areset = 1'b0;

    // zero-wait write, 3-cycle latency
    issue(1'b1, 1'b0, 21'h00040, 32'h1234_5678, 4'hF, 21'h0);
    wait_cpl(20, n);
    chk("t1_latency", n, 3);
    chk("t1_err", cpu_err, 1'b0);
    chk("t1_awaddr", awaddr, 21'h00040);
    chk("t1_wdata", {wdata, wstrb}, {32'h1234_5678, 4'hF});

    // wready 4 cycles before awready
    aw_dly = 4; w_dly = 0;
    issue(1'b1, 1'b0, 21'h00080, 32'h1111_2222, 4'h3, 21'h0);
    @(negedge aclk); @(negedge aclk);
    chk("t2a_w_first", {awvalid, wvalid}, 2'b10);
    wait_cpl(30, n);
    // awready 4 cycles before wready
    aw_dly = 0; w_dly = 4;
    issue(1'b1, 1'b0, 21'h00084, 32'h3333_4444, 4'hC, 21'h0);
    @(negedge aclk); @(negedge aclk);
    chk("t2b_aw_first", {awvalid, wvalid}, 2'b01);
    wait_cpl(30, n);
    w_dly = 0;

    // read with arready delayed 2 cycles, OKAY then SLVERR
    ar_dly = 2; r_data_cfg = 32'hCAFE_0001; r_resp_cfg = 2'b00;
    issue(1'b0, 1'b1, 21'h0, 32'h0, 4'h0, 21'h00100);
    wait_cpl(30, n);
    chk("t3a_rdata", cpu_rd_data, 32'hCAFE_0001);
    chk("t3a_err", cpu_err, 1'b0);
    r_resp_cfg = 2'b10;
    issue(1'b0, 1'b1, 21'h0, 32'h0, 4'h0, 21'h00100);
    wait_cpl(30, n);
    chk("t3b_rdata", cpu_rd_data, 32'hDEAD_BEEF);
    chk("t3b_err", cpu_err, 1'b1);
    ar_dly = 0; r_resp_cfg = 2'b00;

    // simultaneous write and read: write first, read parked
    r_data_cfg = 32'h0BAD_F00D;
    issue(1'b1, 1'b1, 21'h00008, 32'hA5A5_A5A5, 4'hF, 21'h0000C);
    wait_cpl(30, n);
    chk("t4_wr_first", cpu_wr_done, 1'b1);
    chk("t4_busy_pend", cpu_busy, 1'b1);
    wait_cpl(30, n);
    chk("t4_rdata", cpu_rd_data, 32'h0BAD_F00D);
    chk("t4_araddr", araddr, 21'h0000C);

    // slave never answers the write: timeout recovery
    b_en = 1'b0;
    issue(1'b1, 1'b0, 21'h00010, 32'h7777_8888, 4'hF, 21'h0);
    wait_cpl(400, n);
    chk("t5_window", (n >= 255) && (n <= 259), 1'b1);
    chk("t5_err", {cpu_wr_done, cpu_err}, 2'b11);
    chk("t5_dropped", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    slv_clr = 1'b1; b_en = 1'b1;
    r_data_cfg = 32'h1357_2468;
    issue(1'b0, 1'b1, 21'h0, 32'h0, 4'h0, 21'h00020);
    wait_cpl(30, n);
    chk("t5_read_after", {cpu_err, cpu_rd_data}, {1'b0, 32'h1357_2468});

    // reset while waiting in the read-data phase
    r_en = 1'b0;
    issue(1'b0, 1'b1, 21'h0, 32'h0, 4'h0, 21'h00100);
    repeat (4) @(negedge aclk);
    chk("t6_in_rd_data", {rready, cpu_busy}, 2'b11);
    @(posedge aclk); #2;
    areset = 1'b1;
    exp_cpl.delete(); exp_axi.delete(); outstanding = 0;
    @(negedge aclk);
    chk("t6_rst_rready", {rready, cpu_rd_vld, cpu_busy}, 3'b000);
    repeat (2) @(posedge aclk);
    #2 areset = 1'b0;
    r_en = 1'b1; r_data_cfg = 32'h5555_AAAA;
    issue(1'b0, 1'b1, 21'h0, 32'h0, 4'h0, 21'h00200);
    wait_cpl(30, n);
    chk("t6_latency", n, 3);
    chk("t6_rdata", cpu_rd_data, 32'h5555_AAAA);

    repeat (5) @(negedge aclk);
    chk("end_queues", exp_cpl.size() + exp_axi.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
